// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and sequencer sharing one byte-wide SPI master between NREQ requesters.
// The granted requester's byte and {cpol,cpha} are latched at grant. The master is launched
// with a one-cycle active-low strobe. Its busy handshake is followed to completion, and a
// watchdog aborts the transaction if the master hangs. Every output is registered.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   req             per-requester level request, held until that requester's done/err
//   req_data        transmit byte per requester, slot i = [8i+7:8i]
//   req_mode        {cpol,cpha} per requester, slot i = [2i+1:2i]
//   gnt             one-hot grant, held from launch to done/err
//   done, err       one-cycle pulse on the granted bit (completion / watchdog abort)
//   rd_data         received byte, updated only on a completed transfer
//   ctl_busy        high whenever the sequencer is not idle
//   m_en            active-low start strobe to the SPI master
//   m_cpol, m_cpha  mode to the master, stable from grant through the following gap
//   m_data_in       transmit byte to the master
//   m_busy          master busy flag
//   m_data_out      master receive byte
module spi_txn_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [2*NREQ-1:0]   req_mode,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     err,
    output logic [7:0]          rd_data,
    output logic                ctl_busy,
    output logic                m_en,
    output logic                m_cpol,
    output logic                m_cpha,
    output logic [7:0]          m_data_in,
    input  logic                m_busy,
    input  logic [7:0]          m_data_out
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    // The count reaches TIMEOUT-1 on the edge where the counter currently holds TIMEOUT-2.
    localparam logic [WD_W-1:0]  WD_FIRE  = WD_W'(TIMEOUT - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StCapture,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [NREQ-1:0]    err_q, err_d;
    logic [7:0]         rd_q, rd_d;
    logic               en_q, en_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [7:0]         txd_q, txd_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [IDX_W-1:0]   pick;

    // Round-robin scan from last+1. Iterating from the farthest candidate down to the
    // nearest lets the nearest requesting slot win without an early exit.
    always_comb begin
        int unsigned cand;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = (int'(last_q) + k) % NREQ;
            if (req[cand]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        rd_d    = rd_q;
        en_d    = 1'b1;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        txd_d   = txd_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    txd_d       = req_data[8*int'(pick) +: 8];
                    cpol_d      = req_mode[2*int'(pick) + 1];
                    cpha_d      = req_mode[2*int'(pick)];
                    en_d        = 1'b0;
                    last_d      = pick;
                    wd_d        = '0;
                    state_d     = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // Seeing busy rise is not completion, so the watchdog takes priority.
                if (wd_q == WD_FIRE) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (m_busy) begin
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: begin
                if (!m_busy) begin
                    state_d = StCapture;
                end else if (wd_q == WD_FIRE) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StCapture: begin
                rd_d    = m_data_out;
                done_d  = gnt_q;
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                // Grant stays visible alongside the done pulse and clears on the next edge.
                gnt_d = '0;
                if (gap_q == GAP_LAST) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= LAST_RST;
            wd_q    <= '0;
            gap_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rd_q    <= '0;
            en_q    <= 1'b1;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            txd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            en_q    <= en_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rd_q;
    assign ctl_busy  = busy_q;
    assign m_en      = en_q;
    assign m_cpol    = cpol_q;
    assign m_cpha    = cpha_q;
    assign m_data_in = txd_q;

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one byte-wide SPI master between NREQ requesters.
- Latches the granted requester's byte and SPI mode (CPOL/CPHA), then launches the master with a one-cycle active-low start strobe.
- Tracks the master's busy handshake, returns the received byte, and aborts on a hung master via a watchdog.
- Sits between client logic (sensor/config engines) and the SPI master instance.

Parameters:
- NREQ, 3: number of requesters, 2..8.
- GAP_CYCLES, 4: idle cycles enforced between consecutive transactions, at least 1.
- TIMEOUT, 64: watchdog limit, in cycles, for one transaction after launch.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; held until that requester's done or err.
- req_data  in  8*NREQ  transmit byte; requester i uses bits [8i+7:8i].
- req_mode  in  2*NREQ  {cpol,cpha}; requester i uses bits [2i+1:2i].
- gnt  out  NREQ  one-hot grant; held from launch to done/err.
- done  out  NREQ  one-cycle pulse on the granted bit when the transfer completes.
- err  out  NREQ  one-cycle pulse on the granted bit on watchdog abort.
- rd_data  out  8  received byte; valid in the done cycle and held until the next capture.
- ctl_busy  out  1  high whenever state is not IDLE.
- m_en  out  1  start strobe to the SPI master, active-low.
- m_cpol  out  1  clock polarity to the master.
- m_cpha  out  1  clock phase to the master.
- m_data_in  out  8  transmit byte to the master.
- m_busy  in  1  master busy flag.
- m_data_out  in  8  master receive byte.

Behaviour:
- Reset (asynchronous assert, any state, including mid-transfer):
  - state=IDLE; gnt=0, done=0, err=0, rd_data=0, ctl_busy=0.
  - m_en=1, m_cpol=0, m_cpha=0, m_data_in=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first. Watchdog counter=0.
- State machine, all outputs registered:
  - IDLE: if req is nonzero, pick the first set bit scanning last+1, last+2, … (mod NREQ). Next edge: gnt=onehot(i); m_data_in, m_cpol, m_cpha loaded from slot i; m_en=0; last=i; watchdog=0; go to LAUNCH. If req is zero, stay.
  - LAUNCH (exactly 1 cycle): m_en returns to 1; go to WAIT_BUSY.
  - WAIT_BUSY: wait for m_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for m_busy=0, then go to CAPTURE.
  - CAPTURE (1 cycle): rd_data=m_data_out; done=gnt for this cycle only; gnt clears on the following edge; go to GAP.
  - GAP: hold m_en=1 for GAP_CYCLES cycles, then return to IDLE.
- Watchdog: increments every cycle in WAIT_BUSY and WAIT_DONE. When the count reaches TIMEOUT-1 without completion:
  - err=gnt pulses for one cycle; gnt clears.
  - rd_data is left unchanged.
  - go to GAP.
- Latency: req sampled in IDLE at edge t gives gnt and m_en=0 at t+1. done fires 2 cycles after m_busy is seen falling, then GAP_CYCLES more cycles before the next grant is possible.
- Request changes:
  - A requester that drops req mid-transaction does not abort it; done/err still pulse.
  - req, req_data and req_mode are only sampled in IDLE; changes after grant are ignored.
- Fairness:
  - The winner of one transaction has lowest priority at the next IDLE decision.
  - Two requesters held continuously strictly alternate.
  - A lone requester is re-granted after each GAP.
- Mode: m_cpol and m_cpha change only at the IDLE→LAUNCH edge and stay stable through the transfer and GAP.
- done and err are never asserted in the same cycle. At most one bit of gnt, done or err is set at any time.

Test Plan:
- Single request: req=001, data0=8'hA5, mode0=2'b10; master model returns 8'h3C after 8 busy cycles → m_en low for exactly 1 cycle; m_cpol=1, m_cpha=0; done=001 for one cycle; rd_data=8'h3C; ctl_busy low after 4 GAP cycles.
- Contention: req=111 held through 6 transactions → grant order 0,1,2,0,1,2; each transfer uses its own slot data and mode.
- Hung master: m_busy never rises; TIMEOUT=64 → err=gnt pulse 64 cycles after LAUNCH; rd_data unchanged; next request proceeds normally.
- Withdrawal: requester 1 drops req in WAIT_DONE → transfer completes; done=010; the next grant goes to requester 2 if it is requesting.
- Reset mid-transfer: rst=0 during WAIT_DONE → asynchronously gnt=0, m_en=1, ctl_busy=0. After release with req=011, requester 0 is granted first.
- Data change after grant: req_data altered during WAIT_BUSY → m_data_in keeps the value latched at grant.
